// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_pkg
//  Description : Shared types and helpers for the FIFO pointer/flag
//                controller. Provides the per-cycle qualified-operation
//                encoding and a depth helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Qualified operation performed at the next clock edge.
  // Bit 1 = qualified write, bit 0 = qualified read.
  typedef enum logic [1:0] {
    FIFO_NOP = 2'b00,
    FIFO_RD  = 2'b01,
    FIFO_WR  = 2'b10,
    FIFO_RW  = 2'b11
  } fifo_op_t;

  // Number of storage entries addressed by 'aw' address bits.
  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Pointer/flag controller for a register-file FIFO. Produces
//                the storage write strobe and read/write addresses plus
//                full/empty status. Storage read is combinational from
//                r_addr, so the head word is valid whenever empty is low.
//
//  Ports
//    clk      in   1             system clock, rising edge
//    reset_n  in   1             asynchronous active-low reset
//    wr       in   1             producer push request
//    rd       in   1             consumer pop request
//    wr_en    out  1             storage write strobe (qualified push)
//    w_addr   out  ADDR_WIDTH    storage write address
//    r_addr   out  ADDR_WIDTH    storage read address (head)
//    full     out  1             no free entry
//    empty    out  1             no valid entry
//    level    out  ADDR_WIDTH+1  occupancy 0..depth (FIFO_CTRL_LEVEL_EN only)
//
//  Build options
//    FIFO_CTRL_LEVEL_EN : adds the registered 'level' occupancy output.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam logic [ADDR_WIDTH:0] c_ptr_one = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_depth   = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the address bits are equal.
  logic [ADDR_WIDTH:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH:0] r_ptr_q, r_ptr_d;

  logic     do_wr;
  logic     do_rd;
  fifo_op_t op;

  // --------------------------------------------------------------------------
  // Flags from registered pointers
  // --------------------------------------------------------------------------
  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]) &&
                 (w_ptr_q[ADDR_WIDTH]     != r_ptr_q[ADDR_WIDTH]);

  assign w_addr = w_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr = r_ptr_q[ADDR_WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Operation qualification
  // A write into a full FIFO is accepted when a pop happens on the same edge:
  // the head slot (r_addr == w_addr) is read combinationally before the edge
  // overwrites it. A read from an empty FIFO is ignored, and there is no
  // bypass of a same-cycle write to the read side.
  // --------------------------------------------------------------------------
  assign do_wr = wr && (!full || rd);
  assign do_rd = rd && !empty;
  assign wr_en = do_wr;

  assign op = fifo_op_t'({do_wr, do_rd});

  // --------------------------------------------------------------------------
  // Pointer next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    case (op)
      FIFO_WR: w_ptr_d = w_ptr_q + c_ptr_one;
      FIFO_RD: r_ptr_d = r_ptr_q + c_ptr_one;
      FIFO_RW: begin
        w_ptr_d = w_ptr_q + c_ptr_one;
        r_ptr_d = r_ptr_q + c_ptr_one;
      end
      default: begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

`ifdef FIFO_CTRL_LEVEL_EN
  // --------------------------------------------------------------------------
  // Occupancy counter. Kept as its own register so 'level' is a clean flop
  // output; it tracks w_ptr - r_ptr by construction.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    case (op)
      FIFO_WR: level_d = level_q + c_ptr_one;
      FIFO_RD: level_d = level_q - c_ptr_one;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;

  always @(posedge clk) begin
    if (reset_n) begin
      assert (level_q == (w_ptr_q - r_ptr_q));
      assert (level_q <= c_depth);
    end
  end
`endif

  // Full and empty are mutually exclusive whenever the pointers are sane.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(full && empty));
      assert ((w_ptr_q - r_ptr_q) <= c_depth);
    end
  end

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Self-checking bench for fifo_ctrl (ADDR_WIDTH=2, depth 4).
//                A queue-based reference FIFO tracks occupancy and total
//                push/pop counts; a behavioural storage array written from
//                wr_en/w_addr lets popped data be checked against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          wr;
  logic          rd;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [AW:0]   level;
`endif

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .rd      (rd),
    .wr_en   (wr_en),
    .w_addr  (w_addr),
    .r_addr  (r_addr),
    .full    (full),
    .empty   (empty)
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int unsigned   n_push;
  int unsigned   n_pop;
  int unsigned   count;
  logic [31:0]   ref_q[$];
  logic [31:0]   mem [DEPTH];

  int unsigned   n_cmp;
  int unsigned   n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("empty",  32'(empty),  32'(count == 0));
    chk("full",   32'(full),   32'(count == DEPTH));
    chk("w_addr", 32'(w_addr), n_push % DEPTH);
    chk("r_addr", 32'(r_addr), n_pop % DEPTH);
`ifdef FIFO_CTRL_LEVEL_EN
    chk("level",  32'(level),  count);
`endif
  endtask

  task automatic model_reset();
    n_push = 0;
    n_pop  = 0;
    count  = 0;
    ref_q.delete();
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input logic wv, input logic rv);
    logic        exp_wr;
    logic        exp_rd;
    logic [31:0] d;
    wr = wv;
    rd = rv;
    #1;
    check_state();
    exp_wr = wv && ((count < DEPTH) || rv);
    exp_rd = rv && (count > 0);
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    // Head is read before the edge can overwrite it.
    if (exp_rd) begin
      chk("rdata", mem[r_addr], ref_q[0]);
      void'(ref_q.pop_front());
    end
    if (wr_en) begin
      d = $urandom;
      mem[w_addr] = d;
      if (exp_wr) ref_q.push_back(d);
    end
    @(posedge clk);
    if (exp_wr) begin
      n_push++;
      count++;
    end
    if (exp_rd) begin
      n_pop++;
      count--;
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    wr      = 1'b0;
    rd      = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_state();
    reset_n = 1'b1;
    @(negedge clk);

    // Idle, then reads while empty are ignored
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    // Fill to full, then a dropped write
    repeat (5) step(1'b1, 1'b0);

    // Simultaneous read/write while full
    repeat (6) step(1'b1, 1'b1);

    // Drain
    repeat (4) step(1'b0, 1'b1);

    // Simultaneous read/write while empty: write only
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Fill 3 / drain 3 wrap exercise
    for (int r = 0; r < 3; r++) begin
      repeat (3) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1);
    end

    // Asynchronous reset in the middle of a burst
    repeat (2) step(1'b1, 1'b0);
    wr = 1'b1;
    rd = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("wr_en_in_reset", 32'(wr_en), 32'd1);
    wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_state();
    @(negedge clk);
    repeat (2) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1);

    // Randomised traffic with varying bias
    for (int i = 0; i < 400; i++) begin
      int unsigned pw;
      int unsigned pr;
      pw = (i < 200) ? 70 : 35;
      pr = (i < 200) ? 35 : 70;
      step(logic'($urandom_range(0, 99) < pw), logic'($urandom_range(0, 99) < pr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire
